// File: rtl/vdcm_pkg.sv
// Constants and types shared by the encoder-side substream packers and the decoder bitparse.
package vdcm_pkg;

  localparam int unsigned VDCM_DATA_W = 128;
  localparam int unsigned NUM_SSM     = 4;

  typedef logic [$clog2(NUM_SSM)-1:0] ssm_idx_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } pack_state_e;

  // Plain-vector views of the packer states for blocks that keep state in a logic register.
  localparam logic [1:0] ST_ACCUM = 2'(ACCUM);
  localparam logic [1:0] ST_FLUSH = 2'(FLUSH);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

endpackage

// File: rtl/ssm_bitpack_bit_append.sv
// Places one right-aligned code chunk into the packing accumulator directly below the
// bits already held; everything under the new tail stays zero.
module ssm_bitpack_bit_append
  import vdcm_pkg::*;
#(
  parameter int unsigned  DATA_W  = VDCM_DATA_W,
  parameter int unsigned  MAX_LEN = 64,
  localparam int unsigned ACC_W   = DATA_W + MAX_LEN,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  localparam int unsigned FILL_W  = $clog2(DATA_W + MAX_LEN)
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [FILL_W-1:0]  fill,
  input  logic [MAX_LEN-1:0] bits,
  input  logic [LEN_W-1:0]   len,
  output logic [ACC_W-1:0]   acc_next
);

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] masked;
  logic [LEN_W-1:0]   pad;
  logic [ACC_W-1:0]   aligned;
  logic [ACC_W-1:0]   placed;

  // Left-justify the chunk at the accumulator MSB, then slide it down past the held bits.
  always_comb begin
    mask     = ~({MAX_LEN{1'b1}} << len);
    masked   = bits & mask;
    pad      = LEN_W'(MAX_LEN) - len;
    aligned  = {masked, {DATA_W{1'b0}}} << pad;
    placed   = aligned >> fill;
    acc_next = acc | placed;
  end

endmodule

// File: rtl/ssm_bitpack.sv
// Substream bit packer: packs variable-length code chunks MSB-first into DATA_W-bit words
// and zero-pads/flushes the final partial word at end of slice.
module ssm_bitpack
  import vdcm_pkg::*;
#(
  parameter int unsigned  DATA_W  = VDCM_DATA_W,
  parameter int unsigned  MAX_LEN = 64,
  parameter int unsigned  SSM_IDX = 0,
  parameter int unsigned  CNT_W   = 16,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [MAX_LEN-1:0] in_bits,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               in_last,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               done,
  output logic [CNT_W-1:0]   word_cnt
);

  localparam int unsigned       ACC_W     = DATA_W + MAX_LEN;
  localparam int unsigned       FILL_W    = $clog2(DATA_W + MAX_LEN);
  localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(DATA_W);

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_app;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_add;
  logic [FILL_W-1:0] fill_sub;

  ssm_bitpack_bit_append #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) u_append (
    .acc      (acc),
    .fill     (fill),
    .bits     (in_bits),
    .len      (in_len),
    .acc_next (acc_app)
  );

  assign fill_add = fill + FILL_W'(in_len);
  assign fill_sub = fill - FILL_WORD;
  assign out_data = acc[ACC_W-1 -: DATA_W];

  // A full word always blocks input, so input and output never handshake together.
  assign in_rdy = !rst && (state == ST_ACCUM) && (fill < FILL_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      fill     <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (in_vld && in_rdy) begin
            acc  <= acc_app;
            fill <= fill_add;
            if (in_last) begin
              state    <= ST_FLUSH;
              out_vld  <= (fill_add != '0);
              out_last <= (fill_add != '0) && (fill_add <= FILL_WORD);
            end else begin
              out_vld <= (fill_add >= FILL_WORD);
            end
          end else if (out_vld && out_rdy) begin
            acc      <= acc << DATA_W;
            fill     <= fill_sub;
            out_vld  <= 1'b0;
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end

        // Leftover bits after the last chunk drain here; the word holding the final bit is tagged.
        ST_FLUSH: begin
          if (!out_vld) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (out_rdy) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (out_last) begin
              acc      <= '0;
              fill     <= '0;
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              state    <= ST_DONE;
              done     <= 1'b1;
            end else begin
              acc      <= acc << DATA_W;
              fill     <= fill_sub;
              out_vld  <= (fill_sub != '0);
              out_last <= (fill_sub <= FILL_WORD);
            end
          end
        end

        ST_DONE: begin
          state    <= ST_ACCUM;
          acc      <= '0;
          fill     <= '0;
          word_cnt <= '0;
        end

        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

  in_len_legal: assert property (@(posedge clk) disable iff (rst)
                                 in_vld |-> (in_len <= LEN_W'(MAX_LEN)))
    else $error("ssm_bitpack[%0d]: in_len %0d exceeds MAX_LEN", SSM_IDX, in_len);

endmodule

// File: tb/tb_ssm_bitpack.sv
// Randomised scoreboard bench for ssm_bitpack: a bit-queue model predicts the packed words
// and a monitor checks every output handshake and done pulse against it.
module tb_ssm_bitpack;

  localparam int DW = 128;
  localparam int ML = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [ML-1:0] in_bits;
  logic [6:0]    in_len;
  logic          in_last;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;
  logic [15:0]   word_cnt;

  int            tests_run    = 0;
  int            tests_failed = 0;
  bit            model_bits[$];
  logic [DW-1:0] exp_data_q[$];
  bit            exp_last_q[$];
  int            exp_cnt   = 0;
  int            rdy_mode  = 0;
  logic [DW-1:0] last_word = '0;

  ssm_bitpack #(
    .DATA_W  (DW),
    .MAX_LEN (ML),
    .SSM_IDX (2),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_bits  (in_bits),
    .in_len   (in_len),
    .in_last  (in_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the slice is one long bit string, cut into words and zero-padded at the end.
  function automatic void model_accept(input logic [ML-1:0] bits, input int len, input bit last);
    logic [DW-1:0] w;
    for (int i = len - 1; i >= 0; i--) model_bits.push_back(bits[i]);
    while (model_bits.size() >= DW) begin
      for (int k = 0; k < DW; k++) w[DW-1-k] = model_bits.pop_front();
      exp_data_q.push_back(w);
      exp_last_q.push_back(last && (model_bits.size() == 0));
      exp_cnt++;
    end
    if (last && model_bits.size() > 0) begin
      w = '0;
      for (int k = 0; model_bits.size() > 0; k++) w[DW-1-k] = model_bits.pop_front();
      exp_data_q.push_back(w);
      exp_last_q.push_back(1'b1);
      exp_cnt++;
    end
  endfunction

  task automatic apply_stimulus(input logic [ML-1:0] bits, input int len, input bit last);
    int  guard = 0;
    bit  taken = 0;
    in_vld  = 1'b1;
    in_bits = bits;
    in_len  = 7'(len);
    in_last = last;
    while (!taken && guard < 1000) begin
      @(negedge clk);
      taken = in_rdy;
      @(posedge clk);
      guard++;
    end
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
    if (!taken) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout: chunk len %0d not accepted in %0d cycles", len, guard);
    end else begin
      model_accept(bits, len, last);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 1000) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: done not seen within %0d cycles, required a pulse", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_in_rdy_low", in_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_bits.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    check_output("rst_out_vld", out_vld, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_last", out_last, 0);
    check_output("rst_done", done, 0);
    check_output("rst_word_cnt", word_cnt, 0);
    check_output("rst_in_rdy_high", in_rdy, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : ready_driver
    out_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ($urandom_range(0, 3) != 0);
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and audits each done pulse.
  initial begin : monitor
    bit            prev_stall = 0;
    bit            chk_clear  = 0;
    logic [DW-1:0] prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        chk_clear  = 0;
      end else begin
        if (prev_stall) begin
          check_output("stall_hold_vld", out_vld, 1);
          check_output("stall_hold_data", out_data, prev_data);
        end
        if (chk_clear) begin
          check_output("word_cnt_cleared", word_cnt, 0);
          chk_clear = 0;
        end
        if (out_vld) begin
          check_output("in_rdy_while_out_vld", in_rdy, 0);
          if (out_rdy) begin
            if (exp_data_q.size() == 0) begin
              tests_run++;
              tests_failed++;
              $display("[TB] FAIL unexpected_word: got %h, expected no word", out_data);
            end else begin
              check_output("out_data", out_data, exp_data_q.pop_front());
              check_output("out_last", out_last, exp_last_q.pop_front());
            end
            last_word = out_data;
          end
        end
        prev_stall = out_vld && !out_rdy;
        prev_data  = out_data;
        if (done) begin
          check_output("done_word_cnt", word_cnt, 16'(exp_cnt));
          check_output("done_words_pending", exp_data_q.size(), 0);
          exp_cnt   = 0;
          chk_clear = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_bits = '0;
    in_len  = '0;
    in_last = 1'b0;
    rdy_mode = 0;
    idle(2);
    pulse_reset();

    // Exactly one full word from four 32-bit chunks.
    apply_stimulus(64'hDEADBEEF, 32, 0);
    apply_stimulus(64'h01234567, 32, 0);
    apply_stimulus(64'h89ABCDEF, 32, 0);
    apply_stimulus(64'hCAFEF00D, 32, 1);
    wait_done("t1_done");
    check_output("t1_word", last_word, 128'hDEADBEEF0123456789ABCDEFCAFEF00D);

    // Short padded word; upper in_bits garbage must be ignored.
    apply_stimulus(64'hFFFF_0000_0000_0016, 5, 1);
    wait_done("t2_done");
    check_output("t2_word", last_word, 128'hB0 << 120);

    // Output stall with a full word pending.
    rdy_mode = 2;
    idle(2);
    apply_stimulus({ML{1'b1}}, 64, 0);
    apply_stimulus({ML{1'b1}}, 64, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output("t3_stall_vld", out_vld, 1);
      check_output("t3_stall_in_rdy", in_rdy, 0);
      check_output("t3_stall_data", out_data, {DW{1'b1}});
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    apply_stimulus({ML{1'b1}}, 64, 1);
    wait_done("t3_done");
    check_output("t3_last_word", last_word, {{64{1'b1}}, 64'h0});

    // Pure flush with nothing pending: done two cycles after the accept cycle.
    apply_stimulus(64'h1234, 0, 1);
    @(negedge clk);
    check_output("t4_done_early", done, 0);
    check_output("t4_no_word", out_vld, 0);
    @(negedge clk);
    check_output("t4_done_pulse", done, 1);
    check_output("t4_no_word2", out_vld, 0);
    @(negedge clk);
    check_output("t4_done_one_cycle", done, 0);
    @(posedge clk);
    #1;

    // Reset mid-slice: once with 96 bits held after a word was sent, once with a stalled word.
    apply_stimulus(64'h11111111, 32, 0);
    apply_stimulus(64'h22222222, 32, 0);
    apply_stimulus(64'h33333333, 32, 0);
    apply_stimulus(64'h44444444, 32, 0);
    idle(4);
    rdy_mode = 2;
    idle(2);
    apply_stimulus(64'h55555555, 32, 0);
    apply_stimulus(64'h66666666, 32, 0);
    apply_stimulus(64'h77777777, 32, 0);
    check_output("t5_cnt_before_rst", word_cnt, 1);
    pulse_reset();
    for (int c = 0; c < 4; c++) apply_stimulus(64'h9999_9999, 32, 0);
    @(negedge clk);
    check_output("t5_stalled_vld", out_vld, 1);
    @(posedge clk);
    #1;
    pulse_reset();
    rdy_mode = 0;
    apply_stimulus(64'hA5, 8, 1);
    wait_done("t5_done");
    check_output("t5_new_slice", last_word, 128'hA5 << 120);

    // Random slices with random chunk lengths and random backpressure.
    rdy_mode = 1;
    for (int s = 0; s < 40; s++) begin
      int nchunks;
      nchunks = $urandom_range(1, 10);
      for (int c = 0; c < nchunks; c++) begin
        int len;
        len = ($urandom_range(0, 4) == 0) ? 64 : $urandom_range(0, 64);
        apply_stimulus({$urandom(), $urandom()}, len, c == nchunks - 1);
      end
      wait_done("t6_done");
    end
    rdy_mode = 0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
